change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Dime/nickel change dispenser driving a coin hopper.
// Greedy dime-first payout with per-edge ack timeout.
module change_dispenser #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       change_valid,
   input  logic [3:0] change_in,
   input  logic       hopper_ack,
   input  logic       dime_empty,
   input  logic       nickel_empty,
   output logic       change_ready,
   output logic       eject_dime,
   output logic       eject_nickel,
   output logic       change_done,
   output logic       change_err,
   output logic [3:0] owed_out
);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      EJECT_D,
      EJECT_N,
      GAP,
      DONE,
      FAULT
   } state_t;

   localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

   state_t     state;
   logic [3:0] remaining;
   logic [2:0] residue;
   logic [7:0] timer;
   logic [3:0] rounded;
   logic [2:0] res_in;
   logic [3:0] owed_sum;

   // Split the request into a payable multiple of 5 and a leftover residue
   always_comb begin
      rounded = 4'd0;
      if (change_in >= 4'd15)
         rounded = 4'd15;
      else if (change_in >= 4'd10)
         rounded = 4'd10;
      else if (change_in >= 4'd5)
         rounded = 4'd5;
      res_in   = 3'(change_in - rounded);
      owed_sum = remaining + {1'b0, residue};
   end

   assign change_ready = (state == IDLE);
   assign eject_dime   = (state == EJECT_D);
   assign eject_nickel = (state == EJECT_N);
   assign change_done  = (state == DONE);

   // Main sequencer: payout selection, hopper handshake, timeout, result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         remaining  <= 4'd0;
         residue    <= 3'd0;
         timer      <= 8'd0;
         change_err <= 1'b0;
         owed_out   <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (change_valid) begin
                  remaining  <= rounded;
                  residue    <= res_in;
                  change_err <= 1'b0;
                  owed_out   <= 4'd0;
                  state      <= SELECT;
               end
            end
            SELECT: begin
               if (remaining == 4'd0) begin
                  owed_out   <= owed_sum;
                  change_err <= (residue != 3'd0);
                  state      <= DONE;
               end else if (remaining >= 4'd10 && !dime_empty) begin
                  timer <= TMAX;
                  state <= EJECT_D;
               end else if (remaining >= 4'd5 && !nickel_empty) begin
                  timer <= TMAX;
                  state <= EJECT_N;
               end else begin
                  state <= FAULT;
               end
            end
            EJECT_D: begin
               if (hopper_ack) begin
                  remaining <= remaining - 4'd10;
                  timer     <= TMAX;
                  state     <= GAP;
               end else if (timer == 8'd0) begin
                  state <= FAULT;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            EJECT_N: begin
               if (hopper_ack) begin
                  remaining <= remaining - 4'd5;
                  timer     <= TMAX;
                  state     <= GAP;
               end else if (timer == 8'd0) begin
                  state <= FAULT;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            GAP: begin
               if (!hopper_ack) begin
                  state <= SELECT;
               end else if (timer == 8'd0) begin
                  state <= FAULT;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            FAULT: begin
               change_err <= 1'b1;
               owed_out   <= owed_sum;
               state      <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser.
// Bench plays the hopper and predicts payout arithmetically.
module tb_change_dispenser;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       change_valid = 1'b0;
   logic [3:0] change_in = 4'd0;
   logic       hopper_ack = 1'b0;
   logic       dime_empty = 1'b0;
   logic       nickel_empty = 1'b0;
   logic       change_ready;
   logic       eject_dime;
   logic       eject_nickel;
   logic       change_done;
   logic       change_err;
   logic [3:0] owed_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   change_dispenser #(.ACK_TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .change_valid (change_valid),
      .change_in    (change_in),
      .hopper_ack   (hopper_ack),
      .dime_empty   (dime_empty),
      .nickel_empty (nickel_empty),
      .change_ready (change_ready),
      .eject_dime   (eject_dime),
      .eject_nickel (eject_nickel),
      .change_done  (change_done),
      .change_err   (change_err),
      .owed_out     (owed_out)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_ready"}, change_ready, 1);
      check({tag, "_ejd"}, eject_dime, 0);
      check({tag, "_ejn"}, eject_nickel, 0);
      check({tag, "_done"}, change_done, 0);
      check({tag, "_err"}, change_err, 0);
      check({tag, "_owed"}, owed_out, 0);
   endtask

   // One request, hopper acks dly cycles after eject (never if noack)
   task automatic do_req(input string nm, input logic [3:0] amt,
                         input bit de, input bit ne, input int dly,
                         input bit noack);
      int res, rem, d_exp, n_exp, owed_exp, err_exp;
      int d_got, n_got, cyc, ej_cyc, cnt;
      bit done, both, tmo;
      res = amt % 5;
      rem = amt - res;
      d_exp = de ? 0 : rem / 10;
      rem = rem - 10 * d_exp;
      n_exp = ne ? 0 : rem / 5;
      rem = rem - 5 * n_exp;
      tmo = 0;
      if (noack && (d_exp + n_exp) > 0) begin
         d_exp = 0;
         n_exp = 0;
         rem = amt - res;
         tmo = 1;
      end
      owed_exp = rem + res;
      err_exp = (owed_exp != 0) ? 1 : 0;
      d_got = 0; n_got = 0; ej_cyc = 0; cnt = 0;
      done = 0; both = 0;
      dime_empty = de;
      nickel_empty = ne;
      hopper_ack = 1'b0;
      @(negedge clk);
      check({nm, "_rdy_before"}, change_ready, 1);
      change_valid = 1'b1;
      change_in = amt;
      @(negedge clk);
      check({nm, "_rdy_busy"}, change_ready, 0);
      cyc = 1;
      while (cyc <= 400) begin
         change_valid = 1'($urandom_range(0, 1));
         change_in = 4'($urandom_range(0, 15));
         if (eject_dime && eject_nickel) both = 1;
         if (eject_dime || eject_nickel) ej_cyc++;
         if (change_done) begin
            done = 1;
            break;
         end
         if (hopper_ack && !eject_dime && !eject_nickel) begin
            hopper_ack = 1'b0;
         end else if (!hopper_ack && (eject_dime || eject_nickel)) begin
            cnt++;
            if (!noack && cnt >= dly) begin
               hopper_ack = 1'b1;
               cnt = 0;
               if (eject_dime) d_got++;
               else n_got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      change_valid = 1'b0;
      hopper_ack = 1'b0;
      check({nm, "_done_seen"}, done, 1);
      check({nm, "_owed"}, owed_out, owed_exp);
      check({nm, "_err"}, change_err, err_exp);
      check({nm, "_dimes"}, d_got, d_exp);
      check({nm, "_nickels"}, n_got, n_exp);
      check({nm, "_both_eject"}, both, 0);
      if (tmo) check({nm, "_eject_cycles"}, ej_cyc, TO);
      if (amt < 5) check({nm, "_latency"}, cyc, 2);
      @(negedge clk);
      check({nm, "_done_pulse"}, change_done, 0);
      check({nm, "_rdy_after"}, change_ready, 1);
      check({nm, "_owed_hold"}, owed_out, owed_exp);
   endtask

   initial begin
      int guard;
      #1;
      check_idle_outs("reset0");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rel_no_done", change_done, 0);

      do_req("d15", 4'd15, 0, 0, 2, 0);
      do_req("d10_noDime", 4'd10, 1, 0, 2, 0);
      do_req("d15_empty", 4'd15, 1, 1, 2, 0);
      do_req("d5_timeout", 4'd5, 0, 0, 2, 1);
      do_req("d7", 4'd7, 0, 0, 1, 0);
      do_req("d15_noNick", 4'd15, 0, 1, 3, 0);
      do_req("d4", 4'd4, 0, 0, 1, 0);
      do_req("d0", 4'd0, 0, 0, 1, 0);

      // Reset in the middle of a dime eject
      dime_empty = 1'b0;
      nickel_empty = 1'b0;
      hopper_ack = 1'b0;
      change_in = 4'd15;
      change_valid = 1'b1;
      @(negedge clk);
      change_valid = 1'b0;
      guard = 0;
      while (!eject_dime && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("rst_mid_ejd_seen", eject_dime, 1);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outs("rst_mid");
      @(negedge clk);
      check_idle_outs("rst_hold");
      reset = 1'b1;
      @(negedge clk);
      check("rst_rel_no_done", change_done, 0);
      check("rst_rel_ejd", eject_dime, 0);
      do_req("post_rst0", 4'd0, 0, 0, 1, 0);

      for (int i = 0; i < 30; i++) begin
         do_req($sformatf("rnd%0d", i),
                4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)),
                ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
